jk_ff: RTL and testbench



---
 rtl/jk_ff_pkg.sv | 21 ++
 rtl/jk_ff_d_ff.sv | 27 ++
 rtl/jk_ff.sv | 44 ++++
 tb/tb_jk_ff.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/jk_ff_pkg.sv
// Shared types and constants for the JK flip-flop bank.
// Optional feature macro used by jk_ff: JK_FF_QN_EN (adds the qn port).
package jk_ff_pkg;

  // Per-bit command as the {j,k} pair.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

  // Value every state bit takes while reset is asserted.
  localparam logic Q_RESET_VAL = 1'b0;

  // JK-to-D next-state equation for one bit.
  function automatic logic jk_next(input logic j, input logic k, input logic q);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/jk_ff_d_ff.sv
// Vector D register with asynchronous active-high reset to Q_RESET_VAL.
// This is the only storage element of the JK flip-flop bank.
module d_ff
  import jk_ff_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  // Capture d on each rising edge; reset clears immediately without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= {WIDTH{Q_RESET_VAL}};
    end else begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/jk_ff.sv
// Vectorised edge-triggered JK flip-flop: a D register fed by JK-to-D logic.
// Every bit is independent; q comes straight from the register.
// Optional macro JK_FF_QN_EN: adds output qn = ~q (all ones during reset).
module jk_ff
  import jk_ff_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
`ifdef JK_FF_QN_EN
  ,
  output logic [WIDTH-1:0] qn
`endif
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_next;

  // Per-bit next state from the current register value and the {j,k} command.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_next
    assign d_next[gi] = jk_next(j[gi], k[gi], q_reg[gi]);
  end

  d_ff #(
    .WIDTH(WIDTH)
  ) u_d_ff (
    .clk(clk),
    .rst(rst),
    .d  (d_next),
    .q  (q_reg)
  );

  assign q = q_reg;

`ifdef JK_FF_QN_EN
  // Complement output follows the register, so it reads all ones in reset.
  assign qn = ~q_reg;
`endif

endmodule

// File: tb/tb_jk_ff.sv
// Scoreboard bench for jk_ff (WIDTH = 4). Stimulus pushes expected q per edge,
// a monitor pops and compares after each rising edge. Checks qn when
// JK_FF_QN_EN is defined.
module tb_jk_ff;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] j = '0;
  logic [W-1:0] k = '0;
  logic [W-1:0] q;
`ifdef JK_FF_QN_EN
  logic [W-1:0] qn;
`endif

  jk_ff #(
    .WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .j  (j),
    .k  (k),
    .q  (q)
`ifdef JK_FF_QN_EN
    ,
    .qn (qn)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   model_q[W];

  function automatic void check(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end else begin
      $display("ok   %s: q=%b", name, act);
    end
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = model_q[i];
    return v;
  endfunction

  // Behavioural model: apply the command table bit by bit, then queue the result.
  task automatic step(input logic [W-1:0] jj, input logic [W-1:0] kk,
                      input logic rr, input string tag);
    exp_t e;
    @(negedge clk);
    j   = jj;
    k   = kk;
    rst = rr;
    for (int i = 0; i < W; i++) begin
      if (rr) model_q[i] = 1'b0;
      else begin
        case ({jj[i], kk[i]})
          2'b00:   model_q[i] = model_q[i];
          2'b01:   model_q[i] = 1'b0;
          2'b10:   model_q[i] = 1'b1;
          default: model_q[i] = !model_q[i];
        endcase
      end
    end
    e.q   = model_vec();
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: one comparison per rising edge that has an expectation queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.tag, q, e.q);
`ifdef JK_FF_QN_EN
        check({e.tag, "_qn"}, qn, ~e.q);
`endif
      end
    end
  end

  initial begin
    logic [1:0] seq [13];
    seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b01,
            2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b01};

    // Asynchronous reset with no clock edge involved.
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < W; i++) model_q[i] = 1'b0;
    check("rst_async", q, '0);
`ifdef JK_FF_QN_EN
    check("rst_async_qn", qn, '1);
`endif

    // Reset held through edges, including a toggle command.
    step('0, '0, 1'b1, "rst_hold");
    step('1, '1, 1'b1, "rst_edge_toggle");

    // Directed command sequence after release.
    for (int n = 0; n < 13; n++)
      step({W{seq[n][1]}}, {W{seq[n][0]}}, 1'b0, $sformatf("seq%0d", n));

    // Toggle run from zero.
    for (int n = 0; n < 4; n++)
      step('1, '1, 1'b0, $sformatf("toggle%0d", n));

    // Async reset between edges while q is set.
    step('1, '0, 1'b0, "set_pre_async");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < W; i++) model_q[i] = 1'b0;
    check("async_mid_cycle", q, '0);
    step('1, '0, 1'b0, "set_post_release");

    // Per-bit independence.
    step('0, '1, 1'b0, "vec_clear");
    step(4'b1010, 4'b0110, 1'b0, "vec_mixed");
    step('1, '1, 1'b0, "vec_toggle");

    // Randomized commands with occasional synchronous-to-edge reset.
    for (int n = 0; n < 200; n++)
      step(W'($urandom), W'($urandom), ($urandom_range(0, 15) == 0),
           $sformatf("rand%0d", n));

    // Drain outstanding expectations with a bounded wait.
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
